// File: rtl/lsu_mem_ctrl_if.sv
// Bundle of the LSU request, response and data-memory signals.
//   slave  : the load/store unit side (lsu_mem_ctrl)
//   master : the side that issues requests, consumes responses and
//            models the data memory (pipeline + memory, or a testbench)
// Signals:
//   req_*   request handshake from EX/MEM (valid/ready, store flag, funct3, addr, data)
//   resp_*  held response handshake to writeback (valid/ready, data, error)
//   mem_*   word-wide data memory port (rd/wr strobes, op, addr, wdata, registered rdata)
interface lsu_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [2:0]            mem_op;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_is_store, req_op, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_rd_en, mem_wr_en, mem_op, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_is_store, req_op, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_rd_en, mem_wr_en, mem_op, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of the data memory. Takes one request at a time,
// checks op legality and alignment, and only ever issues word-aligned LW/SW
// accesses to memory. Sub-word loads are lane-selected and extended here;
// SB/SH are done as read-modify-write. Result is held on the response port
// until accepted.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : lsu_mem_ctrl_if.slave (request, response, data memory port)
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | ready for a request (req_ready=1)
// LD_RD     | load: word read strobe to memory
// LD_FMT    | load: capture read data, select lane, extend, register
// ST_WR     | SW: full-word write strobe
// RMW_RD    | SB/SH: read the containing word
// RMW_MRG   | SB/SH: merge store lane into read word, register
// RMW_WR    | SB/SH: write merged word
// RESP      | response held until resp_ready
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    lsu_mem_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_RD,
        S_LD_FMT,
        S_ST_WR,
        S_RMW_RD,
        S_RMW_MRG,
        S_RMW_WR,
        S_RESP
    } state_e;

    localparam logic [2:0] OP_WORD = 3'b010;

    state_e                state_q, state_d;
    logic                  alive_q;
    logic                  is_store_q, is_store_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    // Holds store data from accept; replaced by the merged word for SB/SH.
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  req_illegal;
    logic                  req_misal;
    logic                  req_err;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] ld_fmt;
    logic [DATA_WIDTH-1:0] st_merge;

    // Error decode on the incoming request
    always_comb begin
        req_illegal = 1'b0;
        req_misal   = 1'b0;
        if (bus.req_is_store) begin
            req_illegal = bus.req_op[2] | (bus.req_op[1:0] == 2'b11);
        end else begin
            req_illegal = (bus.req_op[1:0] == 2'b11) | (bus.req_op[2] & bus.req_op[1]);
        end
        case (bus.req_op[1:0])
            2'b01:   req_misal = bus.req_addr[0];
            2'b10:   req_misal = |bus.req_addr[1:0];
            default: req_misal = 1'b0;
        endcase
        req_err = req_illegal | req_misal;
    end

    // Lane extraction and merge against the registered memory read data
    always_comb begin
        byte_sel = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (op_q[1:0])
            2'b00:   ld_fmt = {{24{~op_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   ld_fmt = {{16{~op_q[2] & half_sel[15]}}, half_sel};
            default: ld_fmt = bus.mem_rdata;
        endcase

        st_merge = bus.mem_rdata;
        if (op_q[1:0] == 2'b00) begin
            st_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            st_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            alive_q    <= 1'b0;
            is_store_q <= 1'b0;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            is_store_q <= is_store_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        // alive_q keeps req_ready low while reset is asserted even though
        // the state register already sits in IDLE.
        bus.req_ready  = (state_q == S_IDLE) && alive_q;
        bus.mem_rd_en  = (state_q == S_LD_RD) || (state_q == S_RMW_RD);
        bus.mem_wr_en  = (state_q == S_ST_WR) || (state_q == S_RMW_WR);
        bus.mem_op     = (bus.mem_rd_en || bus.mem_wr_en) ? OP_WORD : 3'b000;
        bus.mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_wdata  = bus.mem_wr_en ? wdata_q : '0;
        bus.resp_valid = (state_q == S_RESP);
        bus.resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
        bus.resp_err   = (state_q == S_RESP) && err_q;

        accept = bus.req_valid && bus.req_ready;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_store_d = bus.req_is_store;
                    op_d       = bus.req_op;
                    addr_d     = bus.req_addr;
                    wdata_d    = bus.req_wdata;
                    rdata_d    = '0;
                    err_d      = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!bus.req_is_store) begin
                        state_d = S_LD_RD;
                    end else if (bus.req_op == OP_WORD) begin
                        state_d = S_ST_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LD_RD:   state_d = S_LD_FMT;
            S_LD_FMT: begin
                rdata_d = ld_fmt;
                state_d = S_RESP;
            end
            S_ST_WR:   state_d = S_RESP;
            S_RMW_RD:  state_d = S_RMW_MRG;
            S_RMW_MRG: begin
                wdata_d = st_merge;
                state_d = S_RMW_WR;
            end
            S_RMW_WR:  state_d = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Only the lane/merge logic reads is_store indirectly via state; keep it
    // latched for visibility of the accepted request.
    logic unused_is_store;
    assign unused_is_store = is_store_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory: 64 words, registered read, preload port for the bench
    logic [31:0] mem [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_data;
        else if (bus.mem_wr_en) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    end

    // Reference memory image, updated only by the model
    logic [31:0] ref_mem [64];

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference rules: access size is 1<<op[1:0]; legal loads {0,1,2,4,5}, stores {0,1,2}
    function automatic logic ref_err(input logic st, input logic [2:0] op, input logic [31:0] a);
        int size;
        bit legal;
        legal = st ? (op <= 3'd2) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        size = 1 << op[1:0];
        return (int'(a[7:0]) % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] op, input logic [1:0] off);
        logic [31:0] v, mask, top;
        if (op[1:0] == 2'b10) return w;
        mask = op[0] ? 32'h0000FFFF : 32'h000000FF;
        top  = op[0] ? 32'h00008000 : 32'h00000080;
        v = (w >> (8 * off)) & mask;
        if (!op[2] && ((v & top) != 0)) v = v - (top << 1);
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] op, input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] mask;
        if (op == 3'd2) return wd;
        mask = op[0] ? 32'h0000FFFF : 32'h000000FF;
        return (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pre_idx  = 6'(idx);
        pre_data = d;
        pre_en   = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
        ref_mem[idx] = d;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic run_req(input logic st, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int hold);
        logic        exp_e;
        logic [31:0] exp_rd, new_word, wr_data, wr_addr, rd_addr, r0;
        int exp_lat, exp_rd_n, exp_wr_n, exp_wr_at;
        int rd_n, wr_n, wr_at, rd_at, resp_at, idx;
        logic e0;

        idx      = int'(addr[7:2]);
        exp_e    = ref_err(st, op, addr);
        exp_rd   = 32'd0;
        new_word = ref_mem[idx];
        exp_rd_n = 0;
        exp_wr_n = 0;
        exp_wr_at = 0;
        if (exp_e) begin
            exp_lat = 1;
        end else if (!st) begin
            exp_rd  = ref_load(ref_mem[idx], op, addr[1:0]);
            exp_lat = 3;
            exp_rd_n = 1;
        end else begin
            new_word = ref_store(ref_mem[idx], op, addr[1:0], wd);
            exp_wr_n = 1;
            if (op == 3'd2) begin
                exp_lat = 2; exp_wr_at = 1;
            end else begin
                exp_lat = 4; exp_wr_at = 3; exp_rd_n = 1;
            end
        end

        wait_ready();
        bus.req_is_store = st;
        bus.req_op       = op;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        rd_n = 0; wr_n = 0; wr_at = 0; rd_at = 0; resp_at = 0;
        wr_data = '0; wr_addr = '0; rd_addr = '0;
        for (int k = 1; k <= 8 && resp_at == 0; k++) begin
            @(negedge clk);
            if (bus.mem_rd_en) begin rd_n++; rd_at = k; rd_addr = bus.mem_addr; end
            if (bus.mem_wr_en) begin wr_n++; wr_at = k; wr_data = bus.mem_wdata; wr_addr = bus.mem_addr; end
            if (bus.resp_valid) resp_at = k;
        end
        chk("resp_latency", 32'(resp_at), 32'(exp_lat));
        chk("resp_err", 32'(bus.resp_err), 32'(exp_e));
        chk("resp_rdata", bus.resp_rdata, exp_rd);
        chk("rd_count", 32'(rd_n), 32'(exp_rd_n));
        chk("wr_count", 32'(wr_n), 32'(exp_wr_n));
        if (exp_rd_n == 1) begin
            chk("rd_cycle", 32'(rd_at), 32'd1);
            chk("rd_addr", rd_addr, addr & 32'hFFFF_FFFC);
        end
        if (exp_wr_n == 1) begin
            chk("wr_cycle", 32'(wr_at), 32'(exp_wr_at));
            chk("wr_data", wr_data, new_word);
            chk("wr_addr", wr_addr, addr & 32'hFFFF_FFFC);
            ref_mem[idx] = new_word;
        end
        last_rdata = bus.resp_rdata;

        // Back-pressure: response must hold and new requests must be ignored
        r0 = bus.resp_rdata;
        e0 = bus.resp_err;
        for (int h = 0; h < hold; h++) begin
            bus.req_valid    = 1'b1;
            bus.req_is_store = 1'($urandom_range(0, 1));
            bus.req_op       = 3'($urandom_range(0, 7));
            bus.req_addr     = 32'($urandom_range(0, 255));
            bus.req_wdata    = $urandom;
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_rdata", bus.resp_rdata, r0);
            chk("hold_err", 32'(bus.resp_err), 32'(e0));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            chk("hold_no_mem", 32'({bus.mem_rd_en, bus.mem_wr_en}), 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("post_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("post_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int wr_seen;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_op       = 3'd0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctrl", 32'({bus.req_ready, bus.resp_valid, bus.resp_err,
                             bus.mem_rd_en, bus.mem_wr_en, bus.mem_op}), 32'd0);
        chk("rst_data", bus.mem_addr | bus.mem_wdata | bus.resp_rdata, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) preload(i, $urandom);
        preload(4, 32'h80FF7F01);

        // Lane extraction on the preloaded word
        run_req(1'b0, 3'b000, 32'h13, 32'h0, 0); chk("plan_lb",  last_rdata, 32'hFFFFFF80);
        run_req(1'b0, 3'b100, 32'h13, 32'h0, 0); chk("plan_lbu", last_rdata, 32'h00000080);
        run_req(1'b0, 3'b001, 32'h12, 32'h0, 0); chk("plan_lh",  last_rdata, 32'hFFFF80FF);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 0); chk("plan_lw",  last_rdata, 32'h80FF7F01);

        // Read-modify-write
        run_req(1'b1, 3'b000, 32'h11, 32'h000000AB, 0);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 0); chk("plan_sb_lw", last_rdata, 32'h80FFAB01);
        preload(4, 32'h80FF7F01);
        run_req(1'b1, 3'b001, 32'h12, 32'h00001234, 0);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 0); chk("plan_sh_lw", last_rdata, 32'h12347F01);
        run_req(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 0);
        run_req(1'b0, 3'b010, 32'h14, 32'h0, 0); chk("plan_sw_lw", last_rdata, 32'hDEADBEEF);

        // Errors
        run_req(1'b0, 3'b010, 32'h12, 32'h0, 0);
        run_req(1'b1, 3'b001, 32'h13, 32'h5555, 0);
        run_req(1'b0, 3'b011, 32'h10, 32'h0, 0);

        // Held response
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 5);

        // Reset in RMW_MRG of SB@0x11
        preload(4, 32'h80FF7F01);
        wait_ready();
        bus.req_is_store = 1'b1;
        bus.req_op       = 3'b000;
        bus.req_addr     = 32'h11;
        bus.req_wdata    = 32'h000000AB;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_rd", 32'(bus.mem_rd_en), 32'd1);
        wr_seen = bus.mem_wr_en ? 1 : 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({bus.req_ready, bus.resp_valid, bus.resp_err,
                                 bus.mem_rd_en, bus.mem_wr_en, bus.mem_op}), 32'd0);
        chk("rst_mid_data", bus.mem_addr | bus.mem_wdata | bus.resp_rdata, 32'd0);
        repeat (2) begin
            @(negedge clk);
            if (bus.mem_wr_en) wr_seen++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_wr_en) wr_seen++;
            chk("rst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        chk("rst_no_write", 32'(wr_seen), 32'd0);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 0); chk("plan_rst_lw", last_rdata, 32'h80FF7F01);

        // Randomized traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            logic        st;
            logic [2:0]  op;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            op = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 2)) | (st ? 3'd0 : 3'($urandom_range(0, 1) << 2))
                                             : 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            run_req(st, op, a, $urandom, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
